osc_voice_mixer: RTL and testbench

//  Downstream of the oscillator stage. Consumes the time-multiplexed signed sine sample, one per (voice, osc) slot.

---
 rtl/osc_mix_pkg.sv | 17 +
 rtl/osc_voice_mixer_if.sv | 30 +++
 rtl/sat_shift.sv | 17 +
 rtl/osc_voice_mixer.sv | 123 ++++++++++++
 tb/tb_osc_voice_mixer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/osc_mix_pkg.sv
// Shared widths and the output clamp for the oscillator voice mixer.
package osc_mix_pkg;
  localparam int SAMPLE_W   = 17;
  localparam int LEVEL_W    = 10;
  localparam int OUT_W      = 16;
  localparam int LEVEL_FRAC = 10;
  localparam int PROD_W     = SAMPLE_W + LEVEL_W + 1;

  function automatic logic signed [OUT_W-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7fff;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return x[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/osc_voice_mixer_if.sv
// Slot stream in, voice and master-mix strobes out; master = slot producer/consumer, slave = mixer.
interface osc_voice_mixer_if #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
);
  import osc_mix_pkg::*;

  logic                       slot_valid;
  logic signed [SAMPLE_W-1:0] sine_in;
  logic [LEVEL_W-1:0]         env_level;
  logic [V_WIDTH-1:0]         vx;
  logic [O_WIDTH-1:0]         ox;
  logic [VOICES-1:0]          voice_free;
  logic signed [OUT_W-1:0]    voice_out;
  logic [V_WIDTH-1:0]         voice_idx;
  logic                       voice_valid;
  logic signed [OUT_W-1:0]    mix_out;
  logic                       mix_valid;

  modport master (
    output slot_valid, sine_in, env_level, vx, ox, voice_free,
    input  voice_out, voice_idx, voice_valid, mix_out, mix_valid
  );

  modport slave (
    input  slot_valid, sine_in, env_level, vx, ox, voice_free,
    output voice_out, voice_idx, voice_valid, mix_out, mix_valid
  );
endinterface

// File: rtl/sat_shift.sv
// Arithmetic right shift followed by a clamp to the signed output range.
module sat_shift
  import osc_mix_pkg::*;
#(
  parameter int IN_W  = 19,
  parameter int SHIFT = 2
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  logic signed [IN_W-1:0] shifted;

  always_comb begin
    shifted = din >>> SHIFT;
    dout    = sat16(32'(shifted));
  end
endmodule

// File: rtl/osc_voice_mixer.sv
// Envelope-scales time-multiplexed oscillator samples, sums them per voice, then sums voices per frame.
// Three register stages advancing on valid slots only; no backpressure.
module osc_voice_mixer
  import osc_mix_pkg::*;
#(
  parameter int VOICES      = 8,
  parameter int V_OSC       = 4,
  parameter int V_WIDTH     = 3,
  parameter int O_WIDTH     = 2,
  parameter int VOICE_SHIFT = 2,
  parameter int MIX_SHIFT   = 3
) (
  input logic               sCLK_XVXENVS,
  input logic               reset_reg_N,
  osc_voice_mixer_if.slave  bus
);
  localparam int VACC_W = SAMPLE_W + O_WIDTH;
  localparam int MACC_W = OUT_W + V_WIDTH;
  localparam logic [O_WIDTH-1:0] LAST_OX = O_WIDTH'(V_OSC - 1);
  localparam logic [V_WIDTH-1:0] LAST_V  = V_WIDTH'(VOICES - 1);

  logic                       s1_vld, s1_free;
  logic signed [SAMPLE_W-1:0] s1_sine;
  logic [LEVEL_W-1:0]         s1_level;
  logic [V_WIDTH-1:0]         s1_vx;
  logic [O_WIDTH-1:0]         s1_ox;

  logic                       s2_vld;
  logic signed [SAMPLE_W-1:0] s2_term;
  logic [V_WIDTH-1:0]         s2_vx;
  logic [O_WIDTH-1:0]         s2_ox;

  logic signed [VACC_W-1:0]   vacc, vsum_next;
  logic signed [MACC_W-1:0]   macc, macc_base, macc_next;
  logic [O_WIDTH-1:0]         exp_ox;
  logic [V_WIDTH-1:0]         cur_vx;
  logic                       seq_ok, ok_next, done;
  logic signed [OUT_W-1:0]    voice_sat, mix_sat;

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      s1_vld   <= 1'b0;
      s1_free  <= 1'b0;
      s1_sine  <= '0;
      s1_level <= '0;
      s1_vx    <= '0;
      s1_ox    <= '0;
    end else begin
      s1_vld <= bus.slot_valid;
      if (bus.slot_valid) begin
        s1_free  <= bus.voice_free[bus.vx];
        s1_sine  <= bus.sine_in;
        s1_level <= bus.env_level;
        s1_vx    <= bus.vx;
        s1_ox    <= bus.ox;
      end
    end
  end

  // Level is zero-extended so 1023 stays positive; the product is Q.10 and always fits 17 bits after the shift.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      s2_vld  <= 1'b0;
      s2_term <= '0;
      s2_vx   <= '0;
      s2_ox   <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_term <= s1_free ? '0 :
                   SAMPLE_W'((PROD_W'(s1_sine) * PROD_W'($signed({1'b0, s1_level}))) >>> LEVEL_FRAC);
        s2_vx   <= s1_vx;
        s2_ox   <= s1_ox;
      end
    end
  end

  // A voice completes only if its oscillators arrived in order for one voice since the last ox==0.
  always_comb begin
    vsum_next = (s2_ox == '0) ? VACC_W'(s2_term) : vacc + VACC_W'(s2_term);
    ok_next   = (s2_ox == '0) || (seq_ok && s2_ox == exp_ox && s2_vx == cur_vx);
    done      = s2_vld && ok_next && (s2_ox == LAST_OX);
    macc_base = (s2_vx == '0) ? '0 : macc;
    macc_next = macc_base + MACC_W'(voice_sat);
  end

  sat_shift #(.IN_W(VACC_W), .SHIFT(VOICE_SHIFT)) u_voice_sat (.din(vsum_next), .dout(voice_sat));
  sat_shift #(.IN_W(MACC_W), .SHIFT(MIX_SHIFT))   u_mix_sat   (.din(macc_next), .dout(mix_sat));

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      vacc            <= '0;
      macc            <= '0;
      exp_ox          <= '0;
      cur_vx          <= '0;
      seq_ok          <= 1'b0;
      bus.voice_out   <= '0;
      bus.voice_idx   <= '0;
      bus.voice_valid <= 1'b0;
      bus.mix_out     <= '0;
      bus.mix_valid   <= 1'b0;
    end else begin
      bus.voice_valid <= 1'b0;
      bus.mix_valid   <= 1'b0;
      if (s2_vld) begin
        vacc   <= vsum_next;
        exp_ox <= s2_ox + O_WIDTH'(1);
        cur_vx <= s2_vx;
        seq_ok <= ok_next && (s2_ox != LAST_OX);
      end
      if (done) begin
        bus.voice_out   <= voice_sat;
        bus.voice_idx   <= s2_vx;
        bus.voice_valid <= 1'b1;
        macc            <= macc_next;
        if (s2_vx == LAST_V) begin
          bus.mix_out   <= mix_sat;
          bus.mix_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_osc_voice_mixer.sv
// Directed bench for osc_voice_mixer: scaling, clamping, full frames, free voices, bubbles, reset.
module tb_osc_voice_mixer;
  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   slot_cyc;

  osc_voice_mixer_if bus ();

  osc_voice_mixer dut (
    .sCLK_XVXENVS (clk),
    .reset_reg_N  (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int v_idx_q[$];
  int v_out_q[$];
  int v_cyc_q[$];
  int m_out_q[$];
  int m_cyc_q[$];

  always @(negedge clk) begin
    if (bus.voice_valid === 1'b1) begin
      v_idx_q.push_back(int'(bus.voice_idx));
      v_out_q.push_back(int'(bus.voice_out));
      v_cyc_q.push_back(cyc);
    end
    if (bus.mix_valid === 1'b1) begin
      m_out_q.push_back(int'(bus.mix_out));
      m_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_q();
    v_idx_q.delete(); v_out_q.delete(); v_cyc_q.delete();
    m_out_q.delete(); m_cyc_q.delete();
  endtask

  task automatic send(input int v, input int o, input int s, input int l);
    @(posedge clk); #1;
    bus.slot_valid = 1'b1;
    bus.vx         = 3'(v);
    bus.ox         = 2'(o);
    bus.sine_in    = 17'(s);
    bus.env_level  = 10'(l);
    slot_cyc       = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.slot_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 5;
    if (bus.voice_out !== 16'sd0) begin bad++; $display("FAIL reset_voice_out got=%0d want=0", bus.voice_out); end
    if (bus.voice_idx !== 3'd0)   begin bad++; $display("FAIL reset_voice_idx got=%0d want=0", bus.voice_idx); end
    if (bus.voice_valid !== 1'b0) begin bad++; $display("FAIL reset_voice_valid got=%b want=0", bus.voice_valid); end
    if (bus.mix_out !== 16'sd0)   begin bad++; $display("FAIL reset_mix_out got=%0d want=0", bus.mix_out); end
    if (bus.mix_valid !== 1'b0)   begin bad++; $display("FAIL reset_mix_valid got=%b want=0", bus.mix_valid); end
  endtask

  task automatic one_voice(input string name, input int v, input int s, input int l, input int exp_out);
    int ox3_cyc;
    clear_q();
    bus.voice_free = '0;
    for (int o = 0; o < 4; o++) send(v, o, s, l);
    ox3_cyc = slot_cyc;
    idle(6);
    total++;
    if (v_out_q.size() != 1) begin
      bad++; $display("FAIL %s_strobes got=%0d want=1", name, v_out_q.size());
    end else begin
      total += 3;
      if (v_out_q[0] != exp_out) begin bad++; $display("FAIL %s_out got=%0d want=%0d", name, v_out_q[0], exp_out); end
      if (v_idx_q[0] != v)       begin bad++; $display("FAIL %s_idx got=%0d want=%0d", name, v_idx_q[0], v); end
      if (v_cyc_q[0] != ox3_cyc + 3) begin
        bad++; $display("FAIL %s_latency got=%0d want=%0d", name, v_cyc_q[0] - ox3_cyc, 3);
      end
    end
    total++;
    if (m_out_q.size() != 0) begin bad++; $display("FAIL %s_no_mix got=%0d want=0", name, m_out_q.size()); end
  endtask

  task automatic test_scaling();
    one_voice("scaling", 0, 65535, 512, 32767);
  endtask

  task automatic test_saturation();
    one_voice("saturation", 2, -65536, 1023, -32768);
  endtask

  // Every voice uses sine 4096 at level 1023 -> term 4092, voice 4092 unless freed.
  task automatic run_frame(input string name, input logic [7:0] mask, input int exp_mix,
                           input bit bubbles, input int abort_v);
    int ox3_cyc[8];
    int exp_v;
    clear_q();
    bus.voice_free = mask;
    for (int v = 0; v < 8; v++) begin
      if (v == abort_v) begin
        send(v, 0, -65536, 1023);
        if (bubbles) idle($urandom_range(0, 2));
        send(v, 1, -65536, 1023);
        if (bubbles) idle($urandom_range(0, 2));
      end
      for (int o = 0; o < 4; o++) begin
        send(v, o, 4096, 1023);
        if (bubbles) idle($urandom_range(0, 2));
      end
      ox3_cyc[v] = slot_cyc;
    end
    idle(6);
    total++;
    if (v_out_q.size() != 8) begin
      bad++; $display("FAIL %s_strobes got=%0d want=8", name, v_out_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_v = mask[i] ? 0 : 4092;
        total += 2;
        if (v_idx_q[i] != i)     begin bad++; $display("FAIL %s_idx%0d got=%0d want=%0d", name, i, v_idx_q[i], i); end
        if (v_out_q[i] != exp_v) begin bad++; $display("FAIL %s_out%0d got=%0d want=%0d", name, i, v_out_q[i], exp_v); end
        if (!bubbles) begin
          total++;
          if (v_cyc_q[i] != ox3_cyc[i] + 3) begin
            bad++; $display("FAIL %s_cyc%0d got=%0d want=%0d", name, i, v_cyc_q[i], ox3_cyc[i] + 3);
          end
        end
      end
    end
    total++;
    if (m_out_q.size() != 1) begin
      bad++; $display("FAIL %s_mix_strobes got=%0d want=1", name, m_out_q.size());
    end else begin
      total++;
      if (m_out_q[0] != exp_mix) begin bad++; $display("FAIL %s_mix got=%0d want=%0d", name, m_out_q[0], exp_mix); end
      if (v_cyc_q.size() == 8) begin
        total++;
        if (m_cyc_q[0] != v_cyc_q[7]) begin
          bad++; $display("FAIL %s_mix_cyc got=%0d want=%0d", name, m_cyc_q[0], v_cyc_q[7]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    run_frame("frame", 8'h00, 4092, 1'b0, -1);
  endtask

  task automatic test_voice_free();
    run_frame("free5", 8'h20, 3580, 1'b0, -1);
  endtask

  task automatic test_bubbles();
    run_frame("bubbles", 8'h00, 4092, 1'b1, 4);
  endtask

  task automatic test_reset_midframe();
    clear_q();
    bus.voice_free = '0;
    send(3, 0, 4096, 1023);
    send(3, 1, 4096, 1023);
    @(posedge clk); #1;
    bus.slot_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (bus.voice_out !== 16'sd0) begin bad++; $display("FAIL midreset_voice_out got=%0d want=0", bus.voice_out); end
    if (bus.voice_valid !== 1'b0) begin bad++; $display("FAIL midreset_voice_valid got=%b want=0", bus.voice_valid); end
    if (bus.mix_out !== 16'sd0)   begin bad++; $display("FAIL midreset_mix_out got=%0d want=0", bus.mix_out); end
    if (bus.mix_valid !== 1'b0)   begin bad++; $display("FAIL midreset_mix_valid got=%b want=0", bus.mix_valid); end
    idle(3);
    rst_n = 1'b1;
    send(3, 2, 4096, 1023);
    send(3, 3, 4096, 1023);
    idle(6);
    total++;
    if (v_out_q.size() != 0) begin bad++; $display("FAIL midreset_stale_voice got=%0d want=0", v_out_q.size()); end
    run_frame("postreset", 8'h00, 4092, 1'b0, -1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.slot_valid = 1'b0;
    bus.sine_in    = '0;
    bus.env_level  = '0;
    bus.vx         = '0;
    bus.ox         = '0;
    bus.voice_free = '0;
    repeat (2) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_scaling();
    test_saturation();
    test_back_to_back();
    test_voice_free();
    test_bubbles();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
